// File: rtl/risc32_boot_loader.sv
// Streams a framed program image into instruction memory, then releases the core.
// Optional trailing checksum word is enabled by defining BOOT_CHECKSUM_EN.
module risc32_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_halted,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              done,
    output logic              err,
    output logic              saw_halt
);

    localparam logic [7:0]  MAGIC = 8'hB0;
    localparam logic [31:0] HLT   = 32'hfc00_0000;
    localparam logic [12:0] DEPTH = 13'(1) << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [12:0]         n_q, n_d;
    logic [12:0]         count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                halted_q, halted_d;
    logic                pc_load_q, pc_load_d;
    logic [31:0]         pc_value_q, pc_value_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                saw_halt_q, saw_halt_d;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    logic [12:0] hdr_end;
    logic        hdr_bad;
    logic        last_word;

    // Range check is done in 13 bits so base+N can exceed the memory depth without wrapping.
    always_comb begin
        hdr_end = {1'b0, s_data[11:0]} + {1'b0, s_data[23:12]};
        hdr_bad = (s_data[31:24] != MAGIC)
               || (s_data[23:12] == 12'd0)
               || ((s_data[11:0] >> ADDR_W) != 12'd0)
               || (hdr_end > DEPTH);
    end

    assign last_word = (count_q + 13'd1) == n_q;

    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE, ST_LOAD: s_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                ST_CHECK:         s_ready = 1'b1;
`endif
                default:          s_ready = 1'b0;
            endcase
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        pc_load_d   = 1'b0;
        pc_value_d  = pc_value_q;
        done_d      = done_q;
        err_d       = err_q;
        saw_halt_d  = saw_halt_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    if (hdr_bad) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        base_d  = s_data[ADDR_W-1:0];
                        n_d     = {1'b0, s_data[23:12]};
                        count_d = 13'd0;
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = 32'd0;
`endif
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + count_q[ADDR_W-1:0];
                    mem_wdata_d = s_data;
                    count_d     = count_q + 13'd1;
                    if (s_data == HLT) saw_halt_d = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d      = csum_q + s_data;
                    if (last_word) state_d = ST_CHECK;
`else
                    if (last_word) state_d = ST_RELEASE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (s_valid) begin
                    if (s_data == csum_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            ST_RELEASE: begin
                pc_load_d  = 1'b1;
                pc_value_d = 32'(base_q);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                halted_d = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                halted_d = 1'b1;
                err_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            n_q         <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b1;
            pc_load_q   <= 1'b0;
            pc_value_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            saw_halt_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            pc_load_q   <= pc_load_d;
            pc_value_q  <= pc_value_d;
            done_q      <= done_d;
            err_q       <= err_d;
            saw_halt_q  <= saw_halt_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_halted = halted_q;
    assign pc_load    = pc_load_q;
    assign pc_value   = pc_value_q;
    assign done       = done_q;
    assign err        = err_q;
    assign saw_halt   = saw_halt_q;

endmodule
